// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: word-addressed instruction memory answering CPU fetches.
// Latency: LATENCY+1 cycles from request acceptance to first rsp_valid cycle.
// Backpressure: one fetch in flight; response held until rsp_ready, req_ready low meanwhile.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   req_valid/ready/addr   fetch request (byte address)
//   rsp_valid/ready        fetch response handshake
//   rsp_data/rsp_err       fetched word (NOP on fault) and fault flag
//   load_en/addr/data      program-load write port, usable in any state
//   err_count              saturating count of faulted responses consumed
module imem_fetch_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic [7:0]  err_count
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [29:0] DEPTH_W   = 30'(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic [3:0]  w_next_cnt;
    logic [31:0] r_addr;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;
    logic        r_rsp_err;
    logic [7:0]  r_err_count;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_enter_resp;
    logic          w_exit_resp;
    logic [31:0]   w_rd_addr;
    logic          w_rd_fault;
    logic [AW-1:0] w_rd_idx;
    logic [31:0]   w_rd_word;
    logic          w_ld_ok;
    logic [AW-1:0] w_ld_idx;

    assign req_ready = (r_state == IDLE) && !reset && !load_en;
    assign w_accept  = req_valid && req_ready;

    // With zero latency the response is formed on the acceptance edge itself,
    // so the live request address is used while IDLE.
    assign w_rd_addr  = (r_state == IDLE) ? req_addr : r_addr;
    assign w_rd_fault = (w_rd_addr[1:0] != 2'b00) || (w_rd_addr[31:2] >= DEPTH_W);
    assign w_rd_idx   = w_rd_addr[AW+1:2];
    assign w_rd_word  = w_rd_fault ? NOP_WORD : r_mem[w_rd_idx];

    assign w_ld_ok  = (load_addr[1:0] == 2'b00) && (load_addr[31:2] < DEPTH_W);
    assign w_ld_idx = load_addr[AW+1:2];

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_enter_resp = 1'b0;
        w_exit_resp  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 0) begin
                        w_next_state = RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_next_state = WAIT;
                        w_next_cnt   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next_state = IDLE;
                    w_exit_resp  = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_addr      <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_accept) begin
                r_addr <= req_addr;
            end
            if (w_enter_resp) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= w_rd_word;
                r_rsp_err   <= w_rd_fault;
            end else if (w_exit_resp) begin
                // Outputs return to zero whenever no response is presented.
                r_rsp_valid <= 1'b0;
                r_rsp_data  <= 32'd0;
                r_rsp_err   <= 1'b0;
                if (r_rsp_err && (r_err_count != 8'hFF)) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end
        end
    end

    // No reset on the storage: program contents survive a CPU reset. The read
    // above uses the pre-edge contents, so a same-edge load returns old data.
    always_ff @(posedge clk) begin
        if (!reset && load_en && w_ld_ok) begin
            r_mem[w_ld_idx] <= load_data;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign err_count = r_err_count;

endmodule
